// File: rtl/uart_pkg.sv
// Shared definitions for the UART register port and its two-master arbiter.
//   - bus widths and register address map
//   - wishbone direction encoding (UART convention: low = write)
//   - arbiter state encoding and request payload struct
package uart_pkg;

  localparam int unsigned UART_ADDR_W    = 2;
  localparam int unsigned UART_DATA_W    = 8;
  localparam int unsigned UART_ARB_CNT_W = 8;

  localparam logic [UART_ADDR_W-1:0] UART_TX_ADDR  = 2'd0;
  localparam logic [UART_ADDR_W-1:0] UART_RX_ADDR  = 2'd1;
  localparam logic [UART_ADDR_W-1:0] UART_DIV_ADDR = 2'd2;

  localparam logic UART_WE_WRITE = 1'b0;
  localparam logic UART_WE_READ  = 1'b1;

  // Read data returned to a master whose transaction timed out.
  localparam logic [UART_DATA_W-1:0] UART_ARB_TOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2,
    ARB_TOUT    = 2'd3
  } uart_arb_state_t;

  // One master's request-side wishbone signals; cyc is the UART's "clk" strobe.
  typedef struct packed {
    logic [UART_ADDR_W-1:0] addr;
    logic [UART_DATA_W-1:0] data;
    logic                   we;
    logic                   cyc;
    logic                   stb;
  } uart_wb_req_t;

endpackage

// File: rtl/uart_arb_timeout.sv
// Saturating 8-bit transaction timer for the UART arbiter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : load the counter with zero (takes priority over enable)
//   enable     : count up by one, saturating at all-ones
//   expired    : the count is one short of LIMIT, so the next enabled
//                cycle is the LIMIT-th one
module uart_arb_timeout
  import uart_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [UART_ARB_CNT_W-1:0] count;

  // Counter: clear wins, then saturating increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + UART_ARB_CNT_W'(1);
    end
  end

  // Flagged a cycle early so the owner can act on the edge that would
  // bring the count to LIMIT; kept independent of enable to avoid a loop.
  assign expired = (count == UART_ARB_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing the UART wishbone register port between two
// masters, with a programmable slave-ack timeout.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   mX_addr/data_in/we  : master X request (we high = read)
//   mX_clk, mX_stb      : master X cycle strobe and select
//   mX_data_out         : master X read data (registered)
//   mX_ack              : master X acknowledge (combinational from slave)
//   s_*                 : forwarded port to the UART (s_data_in/s_ack return)
//   grant               : index of the current or last granted master
//   timeout_err         : one-cycle pulse when a transaction times out
module uart_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_ADDR_W-1:0] m0_addr,
  input  logic [UART_DATA_W-1:0] m0_data_in,
  output logic [UART_DATA_W-1:0] m0_data_out,
  input  logic                   m0_we,
  input  logic                   m0_clk,
  input  logic                   m0_stb,
  output logic                   m0_ack,
  input  logic [UART_ADDR_W-1:0] m1_addr,
  input  logic [UART_DATA_W-1:0] m1_data_in,
  output logic [UART_DATA_W-1:0] m1_data_out,
  input  logic                   m1_we,
  input  logic                   m1_clk,
  input  logic                   m1_stb,
  output logic                   m1_ack,
  output logic [UART_ADDR_W-1:0] s_addr,
  output logic [UART_DATA_W-1:0] s_data_out,
  output logic                   s_we,
  output logic                   s_clk,
  output logic                   s_stb,
  input  logic [UART_DATA_W-1:0] s_data_in,
  input  logic                   s_ack,
  output logic                   grant,
  output logic                   timeout_err
);

  uart_arb_state_t        state_q, state_d;
  logic                   last_q, last_d;
  logic                   grant_d;
  logic [UART_DATA_W-1:0] m0_dout_d, m1_dout_d;
  logic                   tout_d;
  logic                   cnt_clear, cnt_enable, cnt_expired;
  logic                   fwd, g_ack, cap_en;
  logic [UART_DATA_W-1:0] cap_data;
  logic                   m0_req, m1_req;
  uart_wb_req_t           m0_bus, m1_bus, g_bus;

  assign m0_req = m0_stb & m0_clk;
  assign m1_req = m1_stb & m1_clk;

  assign m0_bus = '{addr: m0_addr, data: m0_data_in, we: m0_we, cyc: m0_clk, stb: m0_stb};
  assign m1_bus = '{addr: m1_addr, data: m1_data_in, we: m1_we, cyc: m1_clk, stb: m1_stb};
  assign g_bus  = grant ? m1_bus : m0_bus;

  uart_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // State, round-robin pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      last_q      <= 1'b1;
      grant       <= 1'b0;
      m0_data_out <= '0;
      m1_data_out <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant       <= grant_d;
      m0_data_out <= m0_dout_d;
      m1_data_out <= m1_dout_d;
      timeout_err <= tout_d;
    end
  end

  // Next state, forwarding, acks and read-data capture.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant;
    m0_dout_d  = m0_data_out;
    m1_dout_d  = m1_data_out;
    tout_d     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    fwd        = 1'b0;
    g_ack      = 1'b0;
    cap_en     = 1'b0;
    cap_data   = s_data_in;
    s_addr     = '0;
    s_data_out = '0;
    s_we       = UART_WE_WRITE;
    s_clk      = 1'b0;
    s_stb      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // A slave ack left over from before reset blocks new grants.
        if (!s_ack && (m0_req || m1_req)) begin
          grant_d   = (m0_req && m1_req) ? ~last_q : m1_req;
          cnt_clear = 1'b1;
          state_d   = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        fwd        = 1'b1;
        g_ack      = s_ack;
        cnt_enable = ~s_ack;
        if (!g_bus.stb) begin
          state_d = ARB_IDLE;
          last_d  = grant;
        end else if (s_ack) begin
          state_d = ARB_RELEASE;
          cap_en  = (g_bus.we == UART_WE_READ);
        end else if (cnt_expired) begin
          state_d  = ARB_TOUT;
          tout_d   = 1'b1;
          cap_en   = (g_bus.we == UART_WE_READ);
          cap_data = UART_ARB_TOUT_DATA;
        end
      end
      ARB_RELEASE: begin
        fwd   = 1'b1;
        g_ack = s_ack;
        if (!g_bus.cyc && !s_ack) begin
          state_d = ARB_IDLE;
          last_d  = grant;
        end
      end
      ARB_TOUT: begin
        g_ack = 1'b1;
        if (!g_bus.cyc) begin
          state_d = ARB_IDLE;
          last_d  = grant;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (fwd) begin
      s_addr     = g_bus.addr;
      s_data_out = g_bus.data;
      s_we       = g_bus.we;
      s_clk      = g_bus.cyc;
      s_stb      = g_bus.stb;
    end

    if (cap_en) begin
      if (grant) m1_dout_d = cap_data;
      else       m0_dout_d = cap_data;
    end

    m0_ack = g_ack & ~grant;
    m1_ack = g_ack & grant;
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Self-checking bench for uart_arbiter: a scoreboard holds each expected
// slave transaction (granted master, address, data, direction, read data)
// and a task-driven UART model pops and compares them as they appear.
module tb_uart_arbiter;
  import uart_pkg::*;

  localparam int unsigned TOUT = 4;

  logic       clk, reset;
  logic [1:0] m0_addr, m1_addr, s_addr;
  logic [7:0] m0_data_in, m1_data_in, m0_data_out, m1_data_out;
  logic [7:0] s_data_out, s_data_in;
  logic       m0_we, m1_we, m0_clk, m1_clk, m0_stb, m1_stb, m0_ack, m1_ack;
  logic       s_we, s_clk, s_stb, s_ack, grant, timeout_err;

  typedef struct {
    logic       g;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
  } txn_t;

  txn_t       sb[$];
  logic [7:0] exp_dout [2];
  int         checks;
  int         errors;

  uart_arbiter #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_data_in(m0_data_in), .m0_data_out(m0_data_out),
    .m0_we(m0_we), .m0_clk(m0_clk), .m0_stb(m0_stb), .m0_ack(m0_ack),
    .m1_addr(m1_addr), .m1_data_in(m1_data_in), .m1_data_out(m1_data_out),
    .m1_we(m1_we), .m1_clk(m1_clk), .m1_stb(m1_stb), .m1_ack(m1_ack),
    .s_addr(s_addr), .s_data_out(s_data_out), .s_we(s_we), .s_clk(s_clk),
    .s_stb(s_stb), .s_data_in(s_data_in), .s_ack(s_ack),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Move to just after the falling edge; drives and samples happen here.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic m_drive(input logic m, input logic en, input logic [1:0] a,
                         input logic [7:0] d, input logic we);
    if (m) begin
      m1_addr = a; m1_data_in = d; m1_we = we; m1_stb = en; m1_clk = en;
    end else begin
      m0_addr = a; m0_data_in = d; m0_we = we; m0_stb = en; m0_clk = en;
    end
  endtask

  task automatic m_req(input logic m, input logic [1:0] a, input logic [7:0] d,
                       input logic we, input logic [7:0] rdata, input bit push);
    txn_t t;
    m_drive(m, 1'b1, a, d, we);
    if (push) begin
      t.g = m; t.addr = a; t.wdata = d; t.we = we; t.rdata = rdata;
      sb.push_back(t);
    end
  endtask

  // UART model: wait for a forwarded request, check it against the
  // scoreboard, ack after 'delay' cycles, then let the master release.
  task automatic slave_serve(input int delay);
    txn_t       t;
    int         waited;
    int         gi, oi;
    logic       g_ack, o_ack;
    logic [7:0] g_dout, o_dout;
    waited = 0;
    while (!(s_stb && s_clk) && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (!(s_stb && s_clk)) begin
      errors++;
      $display("FAIL serve_wait: s_stb=%b s_clk=%b after %0d cycles, required 1/1", s_stb, s_clk, waited);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL serve_sb: slave request seen, scoreboard empty, required an entry");
      return;
    end
    t  = sb.pop_front();
    gi = t.g ? 1 : 0;
    oi = t.g ? 0 : 1;
    checks++;
    if ({grant, s_addr, s_data_out, s_we} !== {t.g, t.addr, t.wdata, t.we}) begin
      errors++;
      $display("FAIL serve_req: grant=%b addr=%0d data=%h we=%b, required %b %0d %h %b",
               grant, s_addr, s_data_out, s_we, t.g, t.addr, t.wdata, t.we);
    end
    for (int i = 1; i < delay; i++) begin
      step();
      checks++;
      if ({m0_ack, m1_ack, timeout_err} !== 3'b000) begin
        errors++;
        $display("FAIL ack_early: m0_ack=%b m1_ack=%b tout=%b, required 000", m0_ack, m1_ack, timeout_err);
      end
    end
    step();
    s_ack = 1'b1;
    s_data_in = t.rdata;
    settle();
    g_ack = t.g ? m1_ack : m0_ack;
    o_ack = t.g ? m0_ack : m1_ack;
    checks++;
    if ({g_ack, o_ack, s_data_out, s_we} !== {1'b1, 1'b0, t.wdata, t.we}) begin
      errors++;
      $display("FAIL ack: granted_ack=%b other_ack=%b data=%h we=%b, required 1 0 %h %b",
               g_ack, o_ack, s_data_out, s_we, t.wdata, t.we);
    end
    if (t.we == UART_WE_READ) exp_dout[gi] = t.rdata;
    step();
    g_dout = t.g ? m1_data_out : m0_data_out;
    o_dout = t.g ? m0_data_out : m1_data_out;
    checks++;
    if ({g_dout, o_dout} !== {exp_dout[gi], exp_dout[oi]}) begin
      errors++;
      $display("FAIL data_out: granted=%h other=%h, required %h %h", g_dout, o_dout, exp_dout[gi], exp_dout[oi]);
    end
    m_drive(t.g, 1'b0, t.addr, t.wdata, t.we);
    s_ack = 1'b0;
    step();
    checks++;
    if ({s_stb, s_clk, m0_ack, m1_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL release_idle: s_stb=%b s_clk=%b m0_ack=%b m1_ack=%b, required 0000", s_stb, s_clk, m0_ack, m1_ack);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    m_drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    s_ack = 1'b0;
    s_data_in = 8'h00;
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;
    repeat (3) step();
    checks++;
    if ({m0_ack, m1_ack, s_stb, s_clk, s_we, grant, timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: acks=%b%b s_stb=%b s_clk=%b s_we=%b grant=%b tout=%b, required all 0",
               m0_ack, m1_ack, s_stb, s_clk, s_we, grant, timeout_err);
    end
    checks++;
    if ({s_addr, s_data_out, m0_data_out, m1_data_out} !== 26'b0) begin
      errors++;
      $display("FAIL reset_data: s_addr=%0d s_data=%h m0_dout=%h m1_dout=%h, required 0",
               s_addr, s_data_out, m0_data_out, m1_data_out);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_tie_fairness();
    for (int r = 0; r < 2; r++) begin
      step();
      m_req(1'b0, UART_TX_ADDR, 8'hA0 + 8'(r), UART_WE_WRITE, 8'h00, 1'b1);
      m_req(1'b1, UART_DIV_ADDR, 8'hB0 + 8'(r), UART_WE_WRITE, 8'h00, 1'b1);
      slave_serve(1);
      slave_serve(1);
    end
  endtask

  task automatic test_single_write();
    step();
    m_req(1'b0, UART_TX_ADDR, 8'h41, UART_WE_WRITE, 8'h00, 1'b1);
    step();
    checks++;
    if ({s_stb, s_clk, grant} !== 3'b110) begin
      errors++;
      $display("FAIL grant_latency: s_stb=%b s_clk=%b grant=%b, required 1 1 0", s_stb, s_clk, grant);
    end
    slave_serve(2);
  endtask

  task automatic test_read_capture();
    step();
    m_req(1'b1, UART_RX_ADDR, 8'h00, UART_WE_READ, 8'h5A, 1'b1);
    slave_serve(2);
  endtask

  task automatic test_timeout();
    step();
    m_req(1'b0, UART_RX_ADDR, 8'h00, UART_WE_READ, 8'h00, 1'b0);
    step();
    checks++;
    if ({s_stb, grant, timeout_err} !== 3'b100) begin
      errors++;
      $display("FAIL tout_entry: s_stb=%b grant=%b tout=%b, required 1 0 0", s_stb, grant, timeout_err);
    end
    for (int i = 1; i < int'(TOUT); i++) begin
      step();
      checks++;
      if ({timeout_err, s_stb, m0_ack} !== 3'b010) begin
        errors++;
        $display("FAIL tout_wait%0d: tout=%b s_stb=%b m0_ack=%b, required 0 1 0", i, timeout_err, s_stb, m0_ack);
      end
    end
    step();
    exp_dout[0] = 8'hFF;
    checks++;
    if ({timeout_err, s_stb, s_clk, m0_ack, m1_ack, m0_data_out, m1_data_out} !==
        {5'b10010, exp_dout[0], exp_dout[1]}) begin
      errors++;
      $display("FAIL tout_pulse: tout=%b s_stb=%b s_clk=%b m0_ack=%b m1_ack=%b m0_dout=%h m1_dout=%h, required 1 0 0 1 0 ff %h",
               timeout_err, s_stb, s_clk, m0_ack, m1_ack, m0_data_out, m1_data_out, exp_dout[1]);
    end
    step();
    checks++;
    if ({timeout_err, m0_ack} !== 2'b01) begin
      errors++;
      $display("FAIL tout_hold: tout=%b m0_ack=%b, required 0 1", timeout_err, m0_ack);
    end
    m_drive(1'b0, 1'b0, UART_RX_ADDR, 8'h00, UART_WE_READ);
    step();
    checks++;
    if ({m0_ack, s_stb, m0_data_out} !== {2'b00, 8'hFF}) begin
      errors++;
      $display("FAIL tout_exit: m0_ack=%b s_stb=%b m0_dout=%h, required 0 0 ff", m0_ack, s_stb, m0_data_out);
    end
  endtask

  task automatic test_abort();
    step();
    m_req(1'b0, UART_TX_ADDR, 8'h11, UART_WE_WRITE, 8'h00, 1'b0);
    step();
    m_req(1'b1, UART_DIV_ADDR, 8'h07, UART_WE_WRITE, 8'h00, 1'b1);
    settle();
    checks++;
    if ({grant, s_stb, m1_ack, s_data_out} !== {3'b010, 8'h11}) begin
      errors++;
      $display("FAIL abort_busy: grant=%b s_stb=%b m1_ack=%b data=%h, required 0 1 0 11", grant, s_stb, m1_ack, s_data_out);
    end
    step();
    m_drive(1'b0, 1'b0, UART_TX_ADDR, 8'h11, UART_WE_WRITE);
    step();
    checks++;
    if ({s_stb, s_clk, grant, m0_ack, m1_ack} !== 5'b0) begin
      errors++;
      $display("FAIL abort_idle: s_stb=%b s_clk=%b grant=%b acks=%b%b, required 0", s_stb, s_clk, grant, m0_ack, m1_ack);
    end
    slave_serve(1);
  endtask

  task automatic test_reset_mid();
    txn_t t;
    step();
    m_req(1'b0, UART_RX_ADDR, 8'h00, UART_WE_READ, 8'h00, 1'b0);
    step();
    step();
    s_ack = 1'b1;
    s_data_in = 8'h5A;
    step();
    checks++;
    if ({m0_ack, m0_data_out} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL rst_pre: m0_ack=%b m0_dout=%h, required 1 5a", m0_ack, m0_data_out);
    end
    reset = 1'b1;
    step();
    exp_dout[0] = 8'h00;
    exp_dout[1] = 8'h00;
    checks++;
    if ({m0_ack, m1_ack, s_stb, s_clk, s_we, grant, timeout_err, s_addr, s_data_out, m0_data_out, m1_data_out} !== 33'b0) begin
      errors++;
      $display("FAIL rst_mid: acks=%b%b s_stb=%b s_clk=%b s_we=%b grant=%b tout=%b s_addr=%0d s_data=%h douts=%h/%h, required 0",
               m0_ack, m1_ack, s_stb, s_clk, s_we, grant, timeout_err, s_addr, s_data_out, m0_data_out, m1_data_out);
    end
    reset = 1'b0;
    t.g = 1'b0; t.addr = UART_RX_ADDR; t.wdata = 8'h00; t.we = UART_WE_READ; t.rdata = 8'h3C;
    sb.push_back(t);
    m_req(1'b1, UART_TX_ADDR, 8'hC4, UART_WE_WRITE, 8'h00, 1'b1);
    step();
    checks++;
    if ({s_stb, grant} !== 2'b00) begin
      errors++;
      $display("FAIL stale_ack: s_stb=%b grant=%b, required 0 0", s_stb, grant);
    end
    s_ack = 1'b0;
    slave_serve(1);
    slave_serve(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_tie_fairness();
    test_single_write();
    test_read_capture();
    test_timeout();
    test_abort();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_arbiter.md
# uart_arbiter

Two-master arbiter that shares the single wishbone-style register port of the `uart` block between two requesters, e.g. the CPU and a debug/log streamer. It sits directly in front of `uart`. It grants one master at a time using round-robin priority and forwards that master's handshake to the UART. If the UART does not acknowledge within a programmable number of cycles, the arbiter terminates the transaction itself.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles in BUSY without slave ack before the arbiter terminates the transaction; legal range 1..255.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `m0_addr` in 2: master 0 register address (0 = TX, 1 = RX, 2 = frequency divider).
- `m0_data_in` in 8: master 0 write data.
- `m0_data_out` out 8: master 0 read data, registered.
- `m0_we` in 1: master 0 direction; LOW = write, HIGH = read (UART convention).
- `m0_clk` in 1: master 0 cycle strobe.
- `m0_stb` in 1: master 0 select.
- `m0_ack` out 1: master 0 acknowledge.
- `m1_*`: identical set for master 1.
- `s_addr` out 2, `s_data_out` out 8, `s_we` out 1, `s_clk` out 1, `s_stb` out 1: connect to the UART's `wb_addr`, `wb_data_in`, `wb_we`, `wb_clk`, `wb_stb`.
- `s_data_in` in 8, `s_ack` in 1: connect from the UART's `wb_data_out` and `wb_ack`.
- `grant` out 1: index of the current or last granted master.
- `timeout_err` out 1: one-cycle pulse when a transaction times out.

## Operation
- **Request:** `mX_req = mX_stb & mX_clk`.
- **State register:** `state` ∈ {IDLE, BUSY, RELEASE, TOUT}.
- **Round-robin pointer:** `last` (1 bit), reset value 1, so master 0 wins the first tie.

**IDLE**
- `s_stb`, `s_clk` and both acks are 0.
- If exactly one master requests, grant it.
- If both request, grant `!last`.
- On a grant: register `grant`, clear the timeout counter, go to BUSY.

**BUSY**
- `s_addr`, `s_data_out`, `s_we`, `s_clk` and `s_stb` combinationally follow the granted master.
- `mG_ack = s_ack`; the other master's ack stays 0.
- The counter increments every cycle while `s_ack` = 0.
- On `s_ack` rising with the granted master's `we` = 1 (read): capture `s_data_in` into `mG_data_out`, go to RELEASE.
- On `s_ack` rising for a write: go to RELEASE; data_out is unchanged.
- If the granted master drops `stb` before ack (abort): go to IDLE, set `last = grant`; no data capture.
- If the counter reaches `TIMEOUT_CYCLES` with no ack: go to TOUT and pulse `timeout_err`.

**RELEASE**
- Continue forwarding, and continue `mG_ack = s_ack`.
- When `mG_clk` = 0 and `s_ack` = 0: go to IDLE, set `last = grant`.

**TOUT**
- `s_stb` = `s_clk` = 0.
- `mG_ack` = 1 and `mG_data_out` = 8'hFF (loaded on entry; written for reads only).
- When `mG_clk` = 0: drop ack, go to IDLE, set `last = grant`.

**Other rules**
- Requests from the non-granted master are ignored, not queued; that master holds its request until it is granted.
- Reset values: `mX_ack` = 0, `mX_data_out` = 0, `s_stb` = `s_clk` = `s_we` = 0, `s_addr` = 0, `s_data_out` = 0, `grant` = 0, `timeout_err` = 0, `state` = IDLE, `last` = 1.
- Reset mid-transaction forces all of the above on the next edge. A UART ack still high after reset is ignored until IDLE sees it low.

## Timing
- **Grant latency:** request seen on edge N, BUSY from N+1. The slave sees `stb`/`clk` in cycle N+1.
- **Ack path:** master ack is combinational from `s_ack` in BUSY/RELEASE, so it adds zero cycles to the UART's ack latency.
- **Read data:** valid in `mG_data_out` from the cycle after `s_ack` rises and held until the next read by the same master.
- **Turnaround:** at least one IDLE cycle between consecutive transactions.
- **Timeout:** `timeout_err` pulses exactly `TIMEOUT_CYCLES` cycles after BUSY entry.
- **Counter:** 8 bits, saturating; it never wraps.
- **Simultaneous release and new request:** the release completes first. The new request is arbitrated in IDLE with the updated `last`.

## Structure
- Shared package `uart_pkg` holds:
  - address constants `UART_TX_ADDR` = 0, `UART_RX_ADDR` = 1, `UART_DIV_ADDR` = 2;
  - `UART_WE_WRITE` = 0, `UART_WE_READ` = 1;
  - the arbiter state encoding `uart_arb_state_t`.
- One sub-module, `uart_arb_timeout`: a loadable 8-bit saturating counter with a `clear`, `enable` and `expired` interface.
- Arbitration, muxing and the FSM live in `uart_arbiter` itself.

## Test plan
- **Single write:** m0 writes 8'h41 to addr 0 with a UART model acking 2 cycles later.
  - `s_data_out` = 8'h41, `s_we` = 0 and `m0_ack` rise together.
  - `grant` = 0, and the arbiter returns to IDLE after `m0_clk` falls.
- **Tie and fairness:** both masters request in the same cycle after reset.
  - m0 is served first, then m1.
  - Repeat the tie: m0 is served again only after m1.
  - m1 never sees ack while m0 is granted.
- **Read capture:** m1 reads addr 1 while the model returns 8'h5A.
  - `m1_data_out` = 8'h5A one cycle after ack.
  - `m0_data_out` is unchanged.
- **Timeout:** `TIMEOUT_CYCLES` = 4 and the model never acks.
  - `timeout_err` pulses 4 cycles after BUSY entry.
  - `s_stb` falls, `m0_ack` = 1, and `m0_data_out` = 8'hFF for a read.
- **Abort:** m0 drops `stb` in BUSY before ack.
  - `s_stb` falls the next cycle, the arbiter is in IDLE, and a pending m1 request is granted.
- **Reset mid-transaction:** assert `reset` in RELEASE.
  - All outputs are at their reset values on the next edge, and `last` = 1.
